// File: rtl/tron_pkg.sv
// Shared light-cycle definitions: playfield size, cell addressing, direction
// encoding and the collision-checker state encoding.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
//
// TRAIL_OWNER_EN widens each bitmap cell from {occupied} to {occupied, owner}.
package tron_pkg;

  localparam int SCR_W  = 160;
  localparam int SCR_H  = 120;
  localparam int ADDR_W = 15;

`ifdef TRAIL_OWNER_EN
  localparam int CELL_W = 2;   // {occupied, owner}
`else
  localparam int CELL_W = 1;   // {occupied}
`endif

  // Heading of a cycle as produced by the datapath.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Collision-checker FSM encoding.
  typedef logic [1:0] chk_state_t;
  localparam chk_state_t S_CLEAR = 2'd0;
  localparam chk_state_t S_IDLE  = 2'd1;
  localparam chk_state_t S_READ  = 2'd2;
  localparam chk_state_t S_EVAL  = 2'd3;

  // Row-major cell address for a 160-wide field: y*160 + x == (y<<7)+(y<<5)+x.
  // Out-of-field coordinates still produce an address (it aliases another
  // cell or lands past the field); callers must mask those themselves.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x,
                                                  input logic [6:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 7) + (yy << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/trail_collision_checker_if.sv
// Handshake bundle between the game datapath/control and the trail checker.
// Latency: n/a (wires only).
// Backpressure: chk_valid is held by the master until chk_ready is seen high.
//
// master: drives clear_req, chk_valid/chk_x/chk_y/chk_player; sees the rest.
// slave : the checker; drives clear_busy, chk_ready and the res_* result.
interface trail_collision_checker_if;

  logic       clear_req;
  logic       clear_busy;
  logic       chk_valid;
  logic [7:0] chk_x;
  logic [6:0] chk_y;
  logic       chk_player;
  logic       chk_ready;
  logic       res_valid;
  logic       res_hit;
  logic       res_oob;
  logic       res_owner;

  modport master (
    output clear_req, chk_valid, chk_x, chk_y, chk_player,
    input  clear_busy, chk_ready, res_valid, res_hit, res_oob, res_owner
  );

  modport slave (
    input  clear_req, chk_valid, chk_x, chk_y, chk_player,
    output clear_busy, chk_ready, res_valid, res_hit, res_oob, res_owner
  );

endinterface

// File: rtl/trail_bitmap_ram.sv
// Single-port occupancy bitmap, one word per playfield cell, block-RAM style.
// Latency: read data appears the cycle after the address (read-before-write).
// Backpressure: none; one access per cycle, caller arbitrates the port.
//
// Ports: clk; we/addr/wdata write port; rdata registered read data.
// Contents are deliberately not reset so the array maps onto block RAM.
module trail_bitmap_ram #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Full power-of-two depth so any aliased out-of-field address is a legal
  // index; those reads are discarded by the checker.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/trail_collision_checker.sv
// Trail collision checker: flags out-of-field or already-visited head cells,
// then marks the cell visited. Result res_valid two cycles after acceptance.
// Backpressure: chk_ready is low except in idle; one check per three cycles.
//
// Ports: clk, reset (async, active-high); bus (slave modport) carries
// clear_req/clear_busy, chk_valid/chk_x/chk_y/chk_player/chk_ready and
// res_valid/res_hit/res_oob/res_owner.
// Optional macro TRAIL_OWNER_EN: cells also store the owning player and a hit
// reports it on res_owner; otherwise chk_player is ignored and res_owner is 0.
module trail_collision_checker #(
  parameter int SCR_W  = tron_pkg::SCR_W,
  parameter int SCR_H  = tron_pkg::SCR_H,
  parameter int ADDR_W = tron_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  trail_collision_checker_if.slave  bus
);

  import tron_pkg::CELL_W;
  import tron_pkg::chk_state_t;
  import tron_pkg::S_CLEAR;
  import tron_pkg::S_IDLE;
  import tron_pkg::S_READ;
  import tron_pkg::S_EVAL;
  import tron_pkg::cell_addr;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SCR_W * SCR_H - 1);
  localparam logic [7:0]        X_LIM    = 8'(SCR_W);
  localparam logic [6:0]        Y_LIM    = 7'(SCR_H);

  chk_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] chk_addr;
  logic              pending_clear;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic              res_valid_q;
  logic              res_hit_q;
  logic              res_oob_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [CELL_W-1:0] ram_wdata;
  logic [CELL_W-1:0] ram_rdata;
  logic              oob_now;
  logic              occupied;

  assign bus.chk_ready  = (state == S_IDLE) && !bus.clear_req && !pending_clear;
  assign bus.clear_busy = (state == S_CLEAR);
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hit    = res_hit_q;
  assign bus.res_oob    = res_oob_q;

  assign oob_now  = (x_q >= X_LIM) || (y_q >= Y_LIM);
  assign occupied = ram_rdata[CELL_W-1];

`ifdef TRAIL_OWNER_EN
  logic player_q;
  logic res_owner_q;
  assign bus.res_owner = res_owner_q;
`else
  logic unused_player;
  assign unused_player = bus.chk_player;
  assign bus.res_owner = 1'b0;
`endif

  // RAM port arbitration: the sweep owns it in S_CLEAR, the incoming
  // coordinate is looked up in S_IDLE, and the visited mark lands in S_EVAL.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = chk_addr;
    ram_wdata = '0;
    case (state)
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
      end
      S_IDLE: begin
        ram_addr = ADDR_W'(cell_addr(bus.chk_x, bus.chk_y));
      end
      S_EVAL: begin
        // Out-of-field coordinates alias real cells, so they must not write.
        ram_we = !res_oob_q;
`ifdef TRAIL_OWNER_EN
        ram_wdata = {1'b1, player_q};
`else
        ram_wdata = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_CLEAR;
      clr_addr      <= '0;
      chk_addr      <= '0;
      pending_clear <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      res_valid_q   <= 1'b0;
      res_hit_q     <= 1'b0;
      res_oob_q     <= 1'b0;
`ifdef TRAIL_OWNER_EN
      player_q      <= 1'b0;
      res_owner_q   <= 1'b0;
`endif
    end else begin
      res_valid_q <= 1'b0;
      case (state)
        S_CLEAR: begin
          pending_clear <= 1'b0;
          if (bus.clear_req) begin
            clr_addr <= '0;                 // restart the sweep from the top
          end else if (clr_addr == CLR_LAST) begin
            clr_addr <= '0;
            state    <= S_IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end

        S_IDLE: begin
          if (bus.clear_req || pending_clear) begin
            // clear wins over a coincident coordinate, which is not accepted
            clr_addr      <= '0;
            pending_clear <= 1'b0;
            state         <= S_CLEAR;
          end else if (bus.chk_valid) begin
            x_q      <= bus.chk_x;
            y_q      <= bus.chk_y;
            chk_addr <= ram_addr;
`ifdef TRAIL_OWNER_EN
            player_q <= bus.chk_player;
`endif
            state    <= S_READ;
          end
        end

        S_READ: begin
          // RAM data for the accepted cell is valid now; register the result
          // so it is presented during S_EVAL alongside the visited write.
          if (bus.clear_req) begin
            pending_clear <= 1'b1;
          end
          res_valid_q <= 1'b1;
          res_oob_q   <= oob_now;
          res_hit_q   <= !oob_now && occupied;
`ifdef TRAIL_OWNER_EN
          res_owner_q <= (!oob_now && occupied) ? ram_rdata[0] : 1'b0;
`endif
          state       <= S_EVAL;
        end

        S_EVAL: begin
          if (pending_clear) begin
            clr_addr      <= '0;
            pending_clear <= 1'b0;
            state         <= S_CLEAR;
          end else begin
            // a request arriving now is remembered and honoured from idle
            pending_clear <= bus.clear_req;
            state         <= S_IDLE;
          end
        end

        default: state <= S_CLEAR;
      endcase
    end
  end

  trail_bitmap_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CELL_W)
  ) u_bitmap (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
